// File: rtl/adc_sel_pkg.sv
// rtl/adc_sel_pkg.sv - shared state encoding and select helpers for adc_source_select
package adc_sel_pkg;

  typedef enum logic [1:0] {
    BLANK,
    SETTLE,
    WAIT_SAMPLE,
    STREAM
  } sel_state_t;

  // A select value names a real source only when it is 1..n; 0 and anything above n blank the output.
  function automatic logic sel_in_range(input logic [3:0] sel, input int unsigned n);
    return (sel != 4'd0) && (32'(sel) <= n);
  endfunction

endpackage

// File: rtl/adc_source_select_settle_timer.sv
// rtl/adc_source_select_settle_timer.sv - loadable down-counter timing the post-switch blank window
module settle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Flag the last settle cycle so the FSM leaves SETTLE on the same edge the count expires.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/adc_source_select.sv
// rtl/adc_source_select.sv - registered ADC source mux with settle blanking, valid/ready output and overrun flag
module adc_source_select
  import adc_sel_pkg::*;
#(
  parameter int NUM_SRC       = 3,
  parameter int DATA_W        = 12,
  parameter int SETTLE_CYCLES = 16,
  parameter int SEL_W         = $clog2(NUM_SRC + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          data_select,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic                      hold,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      switching,
  output logic                      overrun
);

  localparam int TW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  sel_state_t        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              switching_q;
  logic              overrun_q;

  logic [DATA_W-1:0] slice_d;
  logic              strobe_d;
  logic              sel_change;
  logic              new_in_range;
  logic              accept;
  logic              capture;
  logic              settle_done;

  always_comb begin
    slice_d  = '0;
    strobe_d = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        slice_d  = src_data[k*DATA_W-1 -: DATA_W];
        strobe_d = src_valid[k-1];
      end
    end
  end

  assign sel_change   = (data_select != sel_q);
  assign new_in_range = sel_in_range(4'(data_select), NUM_SRC);
  assign accept       = out_valid_q && out_ready;
  assign capture      = ((state_q == WAIT_SAMPLE) || (state_q == STREAM)) && strobe_d && !hold;

  settle_timer #(.W(TW)) u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (sel_change),
    .load_val (new_in_range ? TW'(SETTLE_CYCLES) : TW'(0)),
    .done     (settle_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BLANK;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      switching_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (sel_change) begin
      // A select change outranks everything, including a strobe landing in the same cycle.
      sel_q       <= data_select;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (!new_in_range) begin
        state_q     <= BLANK;
        switching_q <= 1'b0;
      end else begin
        state_q     <= (SETTLE_CYCLES == 0) ? WAIT_SAMPLE : SETTLE;
        switching_q <= 1'b1;
      end
    end else begin
      case (state_q)
        BLANK: begin
          switching_q <= 1'b0;
        end
        SETTLE: begin
          if (settle_done) begin
            state_q <= WAIT_SAMPLE;
          end
        end
        WAIT_SAMPLE, STREAM: begin
          if (capture) begin
            out_data_q  <= slice_d;
            out_valid_q <= 1'b1;
            if (out_valid_q && !out_ready) begin
              overrun_q <= 1'b1;
            end
            state_q     <= STREAM;
            switching_q <= 1'b0;
          end else if (accept) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= BLANK;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign switching = switching_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_source_select.sv
// tb/tb_adc_source_select.sv - randomized and directed bench for adc_source_select against a behavioural model
module tb_adc_source_select;

  localparam int NS = 4;
  localparam int DW = 12;
  localparam int SC = 16;
  localparam int SW = $clog2(NS + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic [SW-1:0]     data_select;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_valid;
  logic              hold;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              switching;
  logic              overrun;

  logic [DW-1:0] sv [1:NS];

  int total = 0;
  int bad   = 0;

  // Reference state: what the stream looks like, plus how long ago the select last changed.
  int            m_sel;
  int            m_age;
  logic [DW-1:0] m_data;
  bit            m_valid;
  bit            m_ovr;
  bit            m_got;

  adc_source_select #(
    .NUM_SRC       (NS),
    .DATA_W        (DW),
    .SETTLE_CYCLES (SC),
    .SEL_W         (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_select (data_select),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .hold        (hold),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .switching   (switching),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    src_data = '0;
    for (int k = 1; k <= NS; k++) src_data[k*DW-1 -: DW] = sv[k];
  end

  function automatic bit inr(int s);
    return (s >= 1) && (s <= NS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_age = 0; m_data = '0; m_valid = 0; m_ovr = 0; m_got = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (int'(data_select) != m_sel) begin
      m_sel = int'(data_select); m_age = 0;
      m_data = '0; m_valid = 0; m_ovr = 0; m_got = 0;
    end else begin
      if (inr(m_sel) && m_age >= SC && src_valid[m_sel-1] && !hold) begin
        if (m_valid && !out_ready) m_ovr = 1;
        m_data = sv[m_sel]; m_valid = 1; m_got = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (m_age < 100000) m_age++;
    end
  endtask

  task automatic check_all();
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("switching", 32'(switching), 32'(inr(m_sel) && !m_got));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input int ds, input logic [NS-1:0] vld, input logic h, input logic r);
    data_select = SW'(ds);
    src_valid   = vld;
    hold        = h;
    out_ready   = r;
    step();
  endtask

  initial begin
    reset = 1'b1; data_select = '0; src_valid = '0; hold = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= NS; k++) sv[k] = '0;
    model_reset();
    #1;
    chk("rst_async_data", 32'(out_data), 32'h0);
    step();
    step();
    reset = 1'b0;

    // Source 2 with a strobe every fourth cycle through the settle window.
    sv[2] = 12'h7A3;
    for (int i = 0; i < 40; i++) cyc(2, (i % 4 == 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b1);
    chk("first_7a3", 32'(out_data), 32'h7A3);

    // Stream source 1, then switch to 3 while it strobes from the first cycle.
    for (int i = 0; i < 25; i++) begin
      sv[1] = DW'($urandom);
      cyc(1, 4'b0001, 1'b0, 1'b1);
    end
    for (int j = 0; j < 20; j++) begin
      sv[3] = (j < 17) ? 12'hBAD : 12'h3C3;
      cyc(3, 4'b0100, 1'b0, 1'b1);
    end
    chk("post_settle_3c3", 32'(out_data), 32'h3C3);

    // Two unaccepted captures overrun; a select change clears it.
    for (int i = 0; i < 20; i++) cyc(1, 4'b0000, 1'b0, 1'b0);
    sv[1] = 12'h100; cyc(1, 4'b0001, 1'b0, 1'b0);
    sv[1] = 12'h200; cyc(1, 4'b0001, 1'b0, 1'b0);
    cyc(1, 4'b0000, 1'b0, 1'b0);
    chk("ovr_data", 32'(out_data), 32'h200);
    chk("ovr_flag", 32'(overrun), 32'h1);
    cyc(2, 4'b0000, 1'b0, 1'b0);
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // Accept and capture in the same cycle.
    for (int i = 0; i < 20; i++) cyc(1, 4'b0000, 1'b0, 1'b0);
    sv[1] = 12'h111; cyc(1, 4'b0001, 1'b0, 1'b0);
    sv[1] = 12'h222; cyc(1, 4'b0001, 1'b0, 1'b1);
    chk("acc_cap_valid", 32'(out_valid), 32'h1);
    chk("acc_cap_ovr", 32'(overrun), 32'h0);

    // Hold freezes the output; release lets the next strobe through.
    sv[1] = 12'h333;
    for (int i = 0; i < 3; i++) cyc(1, 4'b0001, 1'b1, 1'b1);
    chk("hold_frozen", 32'(out_data), 32'h222);
    sv[1] = 12'h444; cyc(1, 4'b0001, 1'b0, 1'b1);
    chk("hold_release", 32'(out_data), 32'h444);

    // Out-of-range select blanks regardless of strobes.
    for (int i = 0; i < 5; i++) cyc(NS + 1, 4'b1111, 1'b0, 1'b1);
    chk("oor_blank", 32'(out_data), 32'h0);

    // Random traffic with occasional select changes, including out-of-range ones.
    begin
      int ds;
      ds = 1;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 39) == 0) ds = int'($urandom_range(0, (1 << SW) - 1));
        for (int k = 1; k <= NS; k++) sv[k] = DW'($urandom);
        cyc(ds, NS'($urandom) & NS'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
      end
    end

    // Asynchronous reset in the middle of a settle window.
    for (int i = 0; i < 5; i++) cyc(2, 4'b0010, 1'b0, 1'b1);
    reset = 1'b1;
    #2;
    model_reset();
    chk("rst_mid_switching", 32'(switching), 32'h0);
    check_all();
    step();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) cyc(2, 4'b0010, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_source_select.md
# adc_source_select

Registered, parametrised successor to the combinational R2R data mux. Routes one of `NUM_SRC` ADC measurement streams (raw, averaged, scaled, or further channels) to the display / BIN→BCD path. Blanks the output and waits through a settle window on every source change, and forwards only fresh samples from the newly selected source. Output is a valid/ready stream with hold (freeze) support and overrun flagging.

## Interface
Parameters:
- `NUM_SRC`, 3: number of selectable sources; legal range 1..15.
- `DATA_W`, 12: sample width; narrower sources are zero-extended by the driver.
- `SETTLE_CYCLES`, 16: blank cycles after a source change; 0 is legal.
- `SEL_W`, `$clog2(NUM_SRC+1)`: select width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `data_select`  in  SEL_W  0 = blank; k = source k (1..NUM_SRC); values > NUM_SRC treated as 0.
- `src_data`  in  NUM_SRC*DATA_W  packed sources; source k occupies bits [k*DATA_W-1 -: DATA_W].
- `src_valid`  in  NUM_SRC  one-cycle strobe per source, bit k-1 for source k.
- `hold`  in  1  freeze output; captures suppressed while high.
- `out_data`  out  DATA_W  selected measurement.
- `out_valid`  out  1  sample pending for downstream.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `switching`  out  1  high in SETTLE and WAIT_SAMPLE.
- `overrun`  out  1  sticky: a pending sample was overwritten.

## Operation
- `sel_q` register holds the last `data_select`; a change is `data_select != sel_q`, evaluated every cycle in every state and taking priority over everything else.
- On a change:
  - `out_data` becomes 0, `out_valid` 0, `overrun` 0, `sel_q` updates.
  - Next state is BLANK if the new value is 0 or out of range; otherwise SETTLE with counter loaded to `SETTLE_CYCLES` (or WAIT_SAMPLE directly if `SETTLE_CYCLES`=0).
- States:
  - BLANK: `out_data`=0, `out_valid`=0; all strobes ignored.
  - SETTLE: counter decrements each cycle; strobes ignored; at counter==1 → WAIT_SAMPLE.
  - WAIT_SAMPLE: first selected `src_valid` with `hold`=0 captures → STREAM.
  - STREAM: every selected `src_valid` with `hold`=0 captures.
- Capture loads `out_data` with the source slice and sets `out_valid`.
- Capture while `out_valid`=1 and not accepted in that cycle: data overwritten (latest wins), `out_valid` stays 1, `overrun` set.
- Accept with no capture in the same cycle: `out_valid` → 0. Accept with a capture in the same cycle: new data, `out_valid` stays 1, no overrun.
- `hold`=1: `out_data` frozen; a pending `out_valid` may still be accepted. State and counter keep advancing.
- Strobes from unselected sources are always ignored.

## Timing
- Reset values: state BLANK, `sel_q`=0, counter=0, `out_data`=0, `out_valid`=0, `switching`=0, `overrun`=0. Reset mid-SETTLE or mid-STREAM returns to these values immediately.
- After reset release with `data_select`≠0, the change is detected on the first clock edge.
- Capture latency: strobe in cycle N → `out_data`/`out_valid` updated after edge N+1.
- Select change in cycle N → output blank from edge N+1. The earliest capture is a strobe in cycle N+1+`SETTLE_CYCLES`.
- Simultaneous select change and strobe: the change wins and the strobe is dropped.

## Structure
- Package `adc_sel_pkg`: state enum `sel_state_t` {BLANK, SETTLE, WAIT_SAMPLE, STREAM}, and helper function `sel_in_range(sel, n)`.
- Sub-module `settle_timer`: loadable down-counter with `load`, `load_val`, `done` outputs, width `$clog2(SETTLE_CYCLES+1)`. Instantiated once.
- Top level: FSM, capture/overrun logic, slice extraction.

## Test plan
- Reset, `data_select`=2, `SETTLE_CYCLES`=16, source-2 strobes every 4 cycles with 0x7A3 → `switching` high 16 cycles; first `out_data`=0x7A3 one cycle after the first post-settle strobe.
- In STREAM on source 1, switch to 3 while source 3 strobes immediately → `out_data`=0 throughout settle; pre-settle source-3 strobes never appear.
- `out_ready`=0, two source-1 captures (0x100, 0x200) → `out_data`=0x200, `out_valid`=1, `overrun`=1. Select change clears `overrun`.
- Accept and capture in the same cycle → `out_valid` stays 1, new data shown, `overrun`=0.
- `hold`=1 during strobes → `out_data` unchanged. Release `hold` → next strobe captured.
- `data_select`=NUM_SRC+1 → BLANK, `out_data`=0. Assert reset mid-SETTLE → all outputs 0 asynchronously.
